// File: rtl/change_dispense_ctrl.sv
// Change dispenser: greedy payout over five denominations with an ack handshake and timeout abort.
// Defining CHG_STATS_EN adds per-denomination payout counters and a fault-abort counter.

module change_dispense_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned STOCK_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               chg_valid,
  input  logic [15:0]        chg_amount,
  output logic               chg_ready,
  input  logic               stock_ld,
  input  logic [2:0]         stock_sel,
  input  logic [STOCK_W-1:0] stock_val,
  output logic               pay_valid,
  output logic [2:0]         pay_denom,
  input  logic               pay_ack,
  output logic               done,
  output logic               short,
  output logic               fault,
  output logic [15:0]        remainder,
  input  logic [2:0]         stat_sel,
  output logic [15:0]        stat_cnt
);

  localparam int unsigned N_DEN = 5;
  localparam int unsigned TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  function automatic logic [15:0] den_val(input logic [2:0] idx);
    case (idx)
      3'd0:    den_val = 16'd100;
      3'd1:    den_val = 16'd50;
      3'd2:    den_val = 16'd20;
      3'd3:    den_val = 16'd10;
      default: den_val = 16'd5;
    endcase
  endfunction

  state_t             r_state;
  logic [STOCK_W-1:0] r_stock [N_DEN];
  logic [15:0]        r_rem;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_chg_ready;
  logic               r_pay_valid;
  logic [2:0]         r_pay_denom;
  logic               r_done;
  logic               r_short;
  logic               r_fault;
  logic [15:0]        r_remainder;

  logic               w_found;
  logic [2:0]         w_sel;
  logic [15:0]        w_stat;

  // Largest payable denomination = lowest index that fits and is in stock
  always_comb begin
    w_found = 1'b0;
    w_sel   = 3'd0;
    for (int i = 0; i < N_DEN; i++) begin
      if (!w_found && (r_stock[i] != '0) && (den_val(3'(i)) <= r_rem)) begin
        w_found = 1'b1;
        w_sel   = 3'(i);
      end
    end
  end

`ifdef CHG_STATS_EN
  logic [15:0] r_stat [N_DEN+1];

  always_comb begin
    w_stat = 16'd0;
    for (int i = 0; i < N_DEN + 1; i++) begin
      if (stat_sel == 3'(i)) w_stat = r_stat[i];
    end
  end
`else
  logic w_unused_stat;
  assign w_unused_stat = ^stat_sel;
  assign w_stat        = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= 16'd0;
      r_to_cnt    <= '0;
      r_chg_ready <= 1'b1;
      r_pay_valid <= 1'b0;
      r_pay_denom <= 3'd0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_fault     <= 1'b0;
      r_remainder <= 16'd0;
      for (int i = 0; i < N_DEN; i++) r_stock[i] <= '0;
`ifdef CHG_STATS_EN
      for (int i = 0; i < N_DEN + 1; i++) r_stat[i] <= 16'd0;
`endif
    end else begin
      // Completion fields are only meaningful during the done pulse
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_fault     <= 1'b0;
      r_remainder <= 16'd0;
      case (r_state)
        IDLE: begin
          if (stock_ld) begin
            for (int i = 0; i < N_DEN; i++) begin
              if (stock_sel == 3'(i)) r_stock[i] <= stock_val;
            end
          end
          if (chg_valid) begin
            r_rem       <= chg_amount;
            r_chg_ready <= 1'b0;
            r_state     <= SELECT;
          end
        end
        SELECT: begin
          if (w_found) begin
            r_pay_valid <= 1'b1;
            r_pay_denom <= w_sel;
            r_to_cnt    <= '0;
            r_state     <= ISSUE;
          end else begin
            r_done      <= 1'b1;
            r_short     <= (r_rem != 16'd0);
            r_remainder <= r_rem;
            r_state     <= FINISH;
          end
        end
        ISSUE: begin
          if (pay_ack) begin
            for (int i = 0; i < N_DEN; i++) begin
              if ((r_pay_denom == 3'(i)) && (r_stock[i] != '0)) r_stock[i] <= r_stock[i] - STOCK_W'(1);
`ifdef CHG_STATS_EN
              if ((r_pay_denom == 3'(i)) && (r_stat[i] != 16'hFFFF)) r_stat[i] <= r_stat[i] + 16'd1;
`endif
            end
            r_rem       <= r_rem - den_val(r_pay_denom);
            r_pay_valid <= 1'b0;
            r_state     <= SELECT;
          end else if (r_to_cnt == TO_LAST) begin
            r_pay_valid <= 1'b0;
            r_done      <= 1'b1;
            r_fault     <= 1'b1;
            r_remainder <= r_rem;
            r_state     <= FINISH;
`ifdef CHG_STATS_EN
            if (r_stat[N_DEN] != 16'hFFFF) r_stat[N_DEN] <= r_stat[N_DEN] + 16'd1;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        FINISH: begin
          r_chg_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chg_ready = r_chg_ready;
  assign pay_valid = r_pay_valid;
  assign pay_denom = r_pay_denom;
  assign done      = r_done;
  assign short     = r_short;
  assign fault     = r_fault;
  assign remainder = r_remainder;
  assign stat_cnt  = w_stat;

endmodule
